// File: rtl/ofs_plat_host_chan_wr_burst_arbiter.sv
// Round-robin, burst-locked arbiter sharing one host-channel write port among
// NUM_PORTS requesters, with in-order routing of write responses back to the issuer.
module ofs_plat_host_chan_wr_burst_arbiter #(
    parameter int unsigned NUM_PORTS       = 4,
    parameter int unsigned ADDR_WIDTH      = 42,
    parameter int unsigned DATA_WIDTH      = 512,
    parameter int unsigned BURST_CNT_WIDTH = 3,
    parameter int unsigned RSP_FIFO_DEPTH  = 64
) (
    input  logic                                  clk,
    input  logic                                  reset,

    input  logic [NUM_PORTS-1:0]                  in_wr_write,
    input  logic [NUM_PORTS-1:0]                  in_wr_request,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]       in_wr_address,
    input  logic [NUM_PORTS*BURST_CNT_WIDTH-1:0]  in_wr_burstcount,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]       in_wr_writedata,
    output logic [NUM_PORTS-1:0]                  in_wr_waitrequest,
    output logic [NUM_PORTS-1:0]                  in_wr_writeresponsevalid,

    output logic                                  out_wr_write,
    output logic                                  out_wr_request,
    output logic [ADDR_WIDTH-1:0]                 out_wr_address,
    output logic [BURST_CNT_WIDTH-1:0]            out_wr_burstcount,
    output logic [DATA_WIDTH-1:0]                 out_wr_writedata,
    input  logic                                  out_wr_waitrequest,
    input  logic                                  out_wr_writeresponsevalid,

    output logic                                  rsp_underflow_err
);

    localparam int unsigned PORT_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned FIFO_AW = $clog2(RSP_FIFO_DEPTH);
    localparam int unsigned CNT_W   = FIFO_AW + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [PORT_W-1:0]          grant_q, grant_d;
    logic [PORT_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [BURST_CNT_WIDTH-1:0] beats_left_q, beats_left_d;

    logic [PORT_W-1:0]          rr_win;
    logic                       rr_found;
    logic [PORT_W:0]            rr_sum;
    logic [PORT_W:0]            rr_nxt_sum;
    logic [PORT_W-1:0]          cur_grant;

    logic [PORT_W-1:0]          fifo_mem [RSP_FIFO_DEPTH];
    logic [FIFO_AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]           count_q;
    logic                       fifo_full, fifo_empty;
    logic                       beat_acc, push, pop;

    logic [NUM_PORTS-1:0]       rsp_valid_q;
    logic                       err_q;

    // First requesting port at or after rr_ptr, wrapping modulo NUM_PORTS
    always_comb begin
        rr_win   = rr_ptr_q;
        rr_found = 1'b0;
        rr_sum   = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            rr_sum = {1'b0, rr_ptr_q} + (PORT_W+1)'(k);
            if (rr_sum >= (PORT_W+1)'(NUM_PORTS)) begin
                rr_sum = rr_sum - (PORT_W+1)'(NUM_PORTS);
            end
            if (!rr_found && in_wr_write[rr_sum[PORT_W-1:0]]) begin
                rr_win   = rr_sum[PORT_W-1:0];
                rr_found = 1'b1;
            end
        end
    end

    assign fifo_full  = (count_q == CNT_W'(RSP_FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign cur_grant  = (state_q == ST_IDLE) ? rr_win : grant_q;

    // A full response FIFO only blocks new bursts, never beats of a burst already started
    assign out_wr_write      = (state_q == ST_IDLE) ? (rr_found && !fifo_full) : in_wr_write[grant_q];
    assign out_wr_request    = (state_q == ST_IDLE) && in_wr_request[cur_grant];
    assign out_wr_address    = in_wr_address[int'(cur_grant)*ADDR_WIDTH +: ADDR_WIDTH];
    assign out_wr_burstcount = in_wr_burstcount[int'(cur_grant)*BURST_CNT_WIDTH +: BURST_CNT_WIDTH];
    assign out_wr_writedata  = in_wr_writedata[int'(cur_grant)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            in_wr_waitrequest[i] = out_wr_waitrequest || (cur_grant != PORT_W'(i)) ||
                                   ((state_q == ST_IDLE) && fifo_full);
        end
    end

    assign beat_acc = out_wr_write && !out_wr_waitrequest;
    assign push     = beat_acc && (state_q == ST_IDLE);
    assign pop      = out_wr_writeresponsevalid && !fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            beats_left_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            beats_left_q <= beats_left_d;
        end
    end

    // Fences and single-line writes complete in IDLE; longer bursts lock the grant
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        beats_left_d = beats_left_q;
        rr_nxt_sum   = {1'b0, rr_win} + (PORT_W+1)'(1);
        if (rr_nxt_sum >= (PORT_W+1)'(NUM_PORTS)) begin
            rr_nxt_sum = '0;
        end
        case (state_q)
            ST_IDLE: begin
                if (push) begin
                    rr_ptr_d = rr_nxt_sum[PORT_W-1:0];
                    if (!out_wr_request && (out_wr_burstcount > BURST_CNT_WIDTH'(1))) begin
                        grant_d      = rr_win;
                        beats_left_d = out_wr_burstcount - BURST_CNT_WIDTH'(1);
                        state_d      = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                if (beat_acc) begin
                    beats_left_d = beats_left_q - BURST_CNT_WIDTH'(1);
                    if (beats_left_q == BURST_CNT_WIDTH'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= rr_win;
        end
    end

    // Response-routing FIFO pointers, occupancy, routed response pulse and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rsp_valid_q <= '0;
            err_q       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
            rsp_valid_q <= pop ? (NUM_PORTS'(1) << fifo_mem[rd_ptr_q]) : '0;
            if (out_wr_writeresponsevalid && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign in_wr_writeresponsevalid = rsp_valid_q;
    assign rsp_underflow_err        = err_q;

endmodule

// File: tb/tb_ofs_plat_host_chan_wr_burst_arbiter.sv
// Bench for the write burst arbiter: arbitration vector table, directed corner
// sequences, then random traffic against a queue-based transaction model.
module tb_ofs_plat_host_chan_wr_burst_arbiter;

    localparam int unsigned NP    = 4;
    localparam int unsigned AW    = 42;
    localparam int unsigned DW    = 512;
    localparam int unsigned BW    = 3;
    localparam int unsigned DEPTH = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NP-1:0]    in_wr_write, in_wr_request, in_wr_waitrequest, in_wr_writeresponsevalid;
    logic [NP*AW-1:0] in_wr_address;
    logic [NP*BW-1:0] in_wr_burstcount;
    logic [NP*DW-1:0] in_wr_writedata;
    logic             out_wr_write, out_wr_request, out_wr_waitrequest, out_wr_writeresponsevalid;
    logic [AW-1:0]    out_wr_address;
    logic [BW-1:0]    out_wr_burstcount;
    logic [DW-1:0]    out_wr_writedata;
    logic             rsp_underflow_err;

    ofs_plat_host_chan_wr_burst_arbiter #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .BURST_CNT_WIDTH(BW), .RSP_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .in_wr_write(in_wr_write), .in_wr_request(in_wr_request),
        .in_wr_address(in_wr_address), .in_wr_burstcount(in_wr_burstcount),
        .in_wr_writedata(in_wr_writedata), .in_wr_waitrequest(in_wr_waitrequest),
        .in_wr_writeresponsevalid(in_wr_writeresponsevalid),
        .out_wr_write(out_wr_write), .out_wr_request(out_wr_request),
        .out_wr_address(out_wr_address), .out_wr_burstcount(out_wr_burstcount),
        .out_wr_writedata(out_wr_writedata), .out_wr_waitrequest(out_wr_waitrequest),
        .out_wr_writeresponsevalid(out_wr_writeresponsevalid),
        .rsp_underflow_err(rsp_underflow_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [NP-1:0] wmask;
        logic          wt;
        logic          exp_write;
        int            exp_port;
    } vec_t;
    vec_t tbl[12];

    // transaction model state for the random phase
    int   lock, left, rr, gp, h, idx;
    int   q[$];
    logic [NP-1:0] exp_rsp;
    logic exp_err, idle, full, exp_out, acc;
    int   m_len[NP], m_beat[NP], m_seq[NP];
    bit   m_busy[NP], m_fence[NP], m_w[NP];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_beat(input string name, input int p);
        chk({name, " write"}, 64'(out_wr_write), 64'd1);
        chk({name, " port"}, 64'(out_wr_writedata[31:0]), 64'(32'hCAFE_0000 + p));
    endtask

    task automatic chk_wait(input string name, input int p, input logic e);
        chk(name, 64'(in_wr_waitrequest[p]), 64'(e));
    endtask

    // Apply one cycle of stimulus just after the edge, return at the falling edge
    task automatic drive(input logic [NP-1:0] w, input logic [NP-1:0] r, input int bc,
                         input logic wt, input logic rs);
        @(posedge clk); #1;
        in_wr_write = w;
        in_wr_request = r;
        out_wr_waitrequest = wt;
        out_wr_writeresponsevalid = rs;
        for (int p = 0; p < NP; p++) begin
            in_wr_address[p*AW +: AW]    = AW'(32'h100 + p);
            in_wr_burstcount[p*BW +: BW] = BW'(bc);
            in_wr_writedata[p*DW +: DW]  = DW'(32'hCAFE_0000 + p);
        end
        #4;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        in_wr_write = '0;
        in_wr_request = '0;
        out_wr_waitrequest = 1'b0;
        out_wr_writeresponsevalid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        in_wr_write = '0; in_wr_request = '0;
        in_wr_address = '0; in_wr_burstcount = '0; in_wr_writedata = '0;
        out_wr_waitrequest = 1'b0; out_wr_writeresponsevalid = 1'b0;

        // single-line arbitration vectors; rr pointer evolves from 0 across entries
        tbl[0]  = '{4'b0000, 1'b0, 1'b0, -1};
        tbl[1]  = '{4'b0101, 1'b0, 1'b1, 0};
        tbl[2]  = '{4'b0101, 1'b0, 1'b1, 2};
        tbl[3]  = '{4'b0101, 1'b0, 1'b1, 0};
        tbl[4]  = '{4'b1000, 1'b1, 1'b1, 3};
        tbl[5]  = '{4'b1010, 1'b0, 1'b1, 1};
        tbl[6]  = '{4'b1010, 1'b0, 1'b1, 3};
        tbl[7]  = '{4'b1111, 1'b0, 1'b1, 0};
        tbl[8]  = '{4'b1110, 1'b0, 1'b1, 1};
        tbl[9]  = '{4'b0011, 1'b0, 1'b1, 0};
        tbl[10] = '{4'b0010, 1'b1, 1'b1, 1};
        tbl[11] = '{4'b0010, 1'b0, 1'b1, 1};

        do_reset();
        drive(4'b0000, 4'b0000, 1, 1'b0, 1'b0);
        chk("reset out_write", 64'(out_wr_write), 64'd0);
        chk("reset rsp", 64'(in_wr_writeresponsevalid), 64'd0);
        chk("reset err", 64'(rsp_underflow_err), 64'd0);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].wmask, 4'b0000, 1, tbl[i].wt, 1'b0);
            chk($sformatf("tbl%0d write", i), 64'(out_wr_write), 64'(tbl[i].exp_write));
            if (tbl[i].exp_write)
                chk($sformatf("tbl%0d port", i), 64'(out_wr_writedata[31:0]),
                    64'(32'hCAFE_0000 + tbl[i].exp_port));
            for (int p = 0; p < NP; p++)
                if (tbl[i].wmask[p])
                    chk_wait($sformatf("tbl%0d wait%0d", i, p), p,
                             tbl[i].wt || (p != tbl[i].exp_port));
        end

        // ports 0 and 2 both burst 4; port 0 holds 4 beats, then port 2
        do_reset();
        for (int b = 0; b < 4; b++) begin
            drive(4'b0101, 4'b0000, 4, 1'b0, 1'b0);
            chk_beat($sformatf("b4 p0 beat%0d", b), 0);
            chk_wait($sformatf("b4 p2 stalled%0d", b), 2, 1'b1);
        end
        for (int b = 0; b < 4; b++) begin
            drive(4'b0100, 4'b0000, 4, 1'b0, 1'b0);
            chk_beat($sformatf("b4 p2 beat%0d", b), 2);
        end
        drive(4'b1111, 4'b0000, 1, 1'b0, 1'b0);
        chk_beat("rr after bursts", 3);

        // port 1 burst 2 with a stall on beat 2 while port 0 waits
        drive(4'b0010, 4'b0000, 2, 1'b0, 1'b0);
        chk_beat("b2 sop", 1);
        drive(4'b0011, 4'b0000, 2, 1'b1, 1'b0);
        chk_beat("b2 stalled beat", 1);
        chk_wait("b2 p0 held", 0, 1'b1);
        chk_wait("b2 p1 stalled", 1, 1'b1);
        drive(4'b0011, 4'b0000, 2, 1'b0, 1'b0);
        chk_beat("b2 beat2", 1);
        chk_wait("b2 p1 accept", 1, 1'b0);
        chk_wait("b2 p0 still held", 0, 1'b1);
        drive(4'b0001, 4'b0000, 1, 1'b0, 1'b0);
        chk_beat("b2 then p0", 0);

        // continuous single writes from all ports, then in-order responses
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 4'b0000, 1, 1'b0, 1'b0);
            chk_beat($sformatf("rr4 grant%0d", i), i % 4);
        end
        for (int i = 0; i < 6; i++) begin
            drive(4'b0000, 4'b0000, 1, 1'b0, (i < 5) ? 1'b1 : 1'b0);
            chk($sformatf("rr4 rsp%0d", i), 64'(in_wr_writeresponsevalid),
                (i == 0) ? 64'd0 : 64'(1 << ((i - 1) % 4)));
        end

        // fence from port 3 with burstcount 4 is a single beat
        drive(4'b1000, 4'b1000, 4, 1'b0, 1'b0);
        chk_beat("fence", 3);
        chk("fence flag", 64'(out_wr_request), 64'd1);
        chk("fence bc", 64'(out_wr_burstcount), 64'd4);
        chk("rsp pulse ends", 64'(in_wr_writeresponsevalid), 64'd0);
        drive(4'b0001, 4'b0000, 1, 1'b0, 1'b1);
        chk_beat("after fence idle", 0);
        chk("after fence flag", 64'(out_wr_request), 64'd0);
        drive(4'b0000, 4'b0000, 1, 1'b0, 1'b1);
        chk("fence rsp", 64'(in_wr_writeresponsevalid), 64'h8);
        drive(4'b0000, 4'b0000, 1, 1'b0, 1'b0);
        chk("post fence rsp", 64'(in_wr_writeresponsevalid), 64'h1);
        chk("no err", 64'(rsp_underflow_err), 64'd0);

        // fill the response FIFO; same-cycle response does not release the stall
        do_reset();
        for (int i = 0; i < 64; i++) begin
            drive(4'b0001, 4'b0000, 1, 1'b0, 1'b0);
            chk_wait($sformatf("fill%0d", i), 0, 1'b0);
        end
        drive(4'b0011, 4'b0000, 1, 1'b0, 1'b1);
        chk("full out_write", 64'(out_wr_write), 64'd0);
        chk_wait("full p0", 0, 1'b1);
        chk_wait("full p1", 1, 1'b1);
        drive(4'b0011, 4'b0000, 1, 1'b0, 1'b0);
        chk_beat("after pop", 1);
        chk_wait("after pop p1", 1, 1'b0);
        chk("after pop rsp", 64'(in_wr_writeresponsevalid), 64'h1);

        // underflow is sticky; reset mid-burst clears everything
        do_reset();
        drive(4'b0000, 4'b0000, 1, 1'b0, 1'b1);
        chk("uf rsp0", 64'(in_wr_writeresponsevalid), 64'd0);
        drive(4'b0000, 4'b0000, 1, 1'b0, 1'b0);
        chk("uf rsp1", 64'(in_wr_writeresponsevalid), 64'd0);
        chk("uf err set", 64'(rsp_underflow_err), 64'd1);
        drive(4'b0000, 4'b0000, 1, 1'b0, 1'b0);
        chk("uf err held", 64'(rsp_underflow_err), 64'd1);
        drive(4'b0001, 4'b0000, 4, 1'b0, 1'b0);
        chk_beat("mid sop", 0);
        drive(4'b0001, 4'b0000, 4, 1'b0, 1'b0);
        chk_beat("mid beat2", 0);
        do_reset();
        drive(4'b0011, 4'b0000, 1, 1'b0, 1'b0);
        chk("reset err cleared", 64'(rsp_underflow_err), 64'd0);
        chk_beat("reset rr0", 0);
        drive(4'b0010, 4'b0000, 1, 1'b0, 1'b0);
        chk_beat("reset idle", 1);
        drive(4'b0000, 4'b0000, 1, 1'b0, 1'b1);
        drive(4'b0000, 4'b0000, 1, 1'b0, 1'b1);
        chk("reset fifo rsp0", 64'(in_wr_writeresponsevalid), 64'h1);
        drive(4'b0000, 4'b0000, 1, 1'b0, 1'b0);
        chk("reset fifo rsp1", 64'(in_wr_writeresponsevalid), 64'h2);
        chk("reset no err", 64'(rsp_underflow_err), 64'd0);

        // random traffic against a transaction-level model
        do_reset();
        lock = -1; left = 0; rr = 0; q.delete(); exp_rsp = '0; exp_err = 1'b0;
        for (int p = 0; p < NP; p++) begin
            m_busy[p] = 0; m_w[p] = 0; m_seq[p] = 0; m_len[p] = 1; m_beat[p] = 0; m_fence[p] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int p = 0; p < NP; p++) begin
                if (!m_w[p]) begin
                    if (!m_busy[p]) begin
                        m_busy[p]  = 1;
                        m_len[p]   = int'($urandom_range(1, 4));
                        m_fence[p] = ($urandom_range(0, 7) == 0);
                        m_beat[p]  = 0;
                    end
                    m_w[p] = ($urandom_range(0, 2) != 0);
                end
                in_wr_write[p]               = m_w[p];
                in_wr_request[p]             = m_fence[p];
                in_wr_address[p*AW +: AW]    = AW'(p*65536 + m_seq[p]);
                in_wr_burstcount[p*BW +: BW] = BW'(m_len[p]);
                in_wr_writedata[p*DW +: DW]  = DW'(p*65536 + m_seq[p]);
            end
            out_wr_waitrequest = ($urandom_range(0, 3) == 0);
            out_wr_writeresponsevalid = (c < 1500) ? ($urandom_range(0, 1) == 1)
                                                   : ($urandom_range(0, 7) == 0);
            #4;
            idle = (lock < 0);
            gp = -1;
            if (!idle) gp = lock;
            else
                for (int k = 0; k < NP; k++) begin
                    idx = (rr + k) % NP;
                    if (gp < 0 && m_w[idx]) gp = idx;
                end
            full = (q.size() >= DEPTH);
            exp_out = (gp >= 0) && m_w[gp] && !(idle && full);
            chk($sformatf("rnd%0d write", c), 64'(out_wr_write), 64'(exp_out));
            if (exp_out) begin
                chk($sformatf("rnd%0d data", c), 64'(out_wr_writedata[31:0]),
                    64'(32'(gp*65536 + m_seq[gp])));
                chk($sformatf("rnd%0d fence", c), 64'(out_wr_request),
                    64'(idle && m_fence[gp]));
                if (idle && !m_fence[gp])
                    chk($sformatf("rnd%0d bc", c), 64'(out_wr_burstcount), 64'(m_len[gp]));
            end
            for (int p = 0; p < NP; p++)
                if (m_w[p])
                    chk_wait($sformatf("rnd%0d wait%0d", c, p), p,
                             out_wr_waitrequest || (p != gp) || (idle && full));
            chk($sformatf("rnd%0d rsp", c), 64'(in_wr_writeresponsevalid), 64'(exp_rsp));
            chk($sformatf("rnd%0d err", c), 64'(rsp_underflow_err), 64'(exp_err));

            acc = exp_out && !out_wr_waitrequest;
            exp_rsp = '0;
            if (out_wr_writeresponsevalid) begin
                if (q.size() > 0) begin
                    h = q.pop_front();
                    exp_rsp[h] = 1'b1;
                end else begin
                    exp_err = 1'b1;
                end
            end
            if (acc) begin
                if (idle) begin
                    q.push_back(gp);
                    rr = (gp + 1) % NP;
                    if (!m_fence[gp] && m_len[gp] > 1) begin
                        lock = gp;
                        left = m_len[gp] - 1;
                    end
                end else begin
                    left--;
                    if (left == 0) lock = -1;
                end
            end
            for (int p = 0; p < NP; p++)
                if (m_w[p] && !in_wr_waitrequest[p]) begin
                    m_beat[p]++;
                    m_seq[p]++;
                    m_w[p] = 0;
                    if (m_fence[p] || m_beat[p] >= m_len[p]) m_busy[p] = 0;
                end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ofs_plat_host_chan_wr_burst_arbiter.md
Name: ofs_plat_host_chan_wr_burst_arbiter

Overview:
Shares one burst-limited host-memory write channel among NUM_PORTS Avalon-style write requesters. It arbitrates round-robin at burst granularity and locks the grant for every beat of a multi-line burst. It records the winning port of each burst in order so that the in-order write responses from the FIU-side channel are steered back to the issuing port. It sits between AFU-side write masters and the write side of the host channel mapper.

Parameters:
NUM_PORTS, 4, number of requesting write masters (2..8)
ADDR_WIDTH, 42, line address width
DATA_WIDTH, 512, line data width
BURST_CNT_WIDTH, 3, burst count width (max burst 4 lines)
RSP_FIFO_DEPTH, 64, outstanding bursts tracked for response routing (power of 2)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_wr_write  in  NUM_PORTS  per-port write beat valid
in_wr_request  in  NUM_PORTS  per-port write fence (single beat, burstcount ignored)
in_wr_address  in  NUM_PORTS*ADDR_WIDTH  per-port line address (SOP beat only)
in_wr_burstcount  in  NUM_PORTS*BURST_CNT_WIDTH  per-port burst length 1..4 (SOP beat only)
in_wr_writedata  in  NUM_PORTS*DATA_WIDTH  per-port beat data
in_wr_waitrequest  out  NUM_PORTS  per-port stall
in_wr_writeresponsevalid  out  NUM_PORTS  per-port write/fence response
out_wr_write  out  1  merged beat valid
out_wr_request  out  1  merged fence flag
out_wr_address  out  ADDR_WIDTH  merged address
out_wr_burstcount  out  BURST_CNT_WIDTH  merged burst count
out_wr_writedata  out  DATA_WIDTH  merged data
out_wr_waitrequest  in  1  downstream stall
out_wr_writeresponsevalid  in  1  downstream response, one per burst/fence, in issue order
rsp_underflow_err  out  1  sticky: response arrived with no tracked burst

Behaviour:
- Beat accepted on a port when in_wr_write[i] && !in_wr_waitrequest[i]; downstream accepted when out_wr_write && !out_wr_waitrequest. The two are equal for the granted port.
- Two states: IDLE (next beat is an SOP) and BURST (locked to grant_q, beats_left > 0).
- IDLE: combinational round-robin over in_wr_write, starting at rr_ptr. Winner g is muxed straight to the out_* signals (zero latency). No requester: out_wr_write=0, other outputs don't-care.
- IDLE, SOP accepted: push g into the response FIFO and set rr_ptr <= (g+1) mod NUM_PORTS.
  - If fence, or burstcount==1: stay IDLE.
  - Otherwise: grant_q <= g, beats_left <= burstcount-1, go to BURST.
- BURST: out_* muxed from grant_q, with out_wr_request forced 0. beats_left decrements on each accepted beat; return to IDLE when an accepted beat sees beats_left==1. No FIFO push mid-burst.
- in_wr_waitrequest[i] = out_wr_waitrequest || (i != current grant) || (IDLE && fifo_full). A full FIFO never stalls mid-burst.
- fifo_full comes from the registered count; no same-cycle pop bypass. Simultaneous push and pop when not full leaves the count unchanged.
- Responses: on out_wr_writeresponsevalid, pop the FIFO head h. Next cycle in_wr_writeresponsevalid is one-hot at bit h (1-cycle registered latency). Push and pop in the same cycle are both honoured.
- Response with FIFO empty: drop it, set rsp_underflow_err (sticky until reset), leave the FIFO unchanged.
- Non-granted ports hold their request; there is no timeout.
- Reset (any cycle, including mid-burst): go to IDLE, rr_ptr=0, beats_left=0, FIFO emptied, in_wr_writeresponsevalid=0, rsp_underflow_err=0. A partial burst in flight is abandoned; clean downstream state is the caller's responsibility.

Test Plan:
- Ports 0 and 2 request simultaneously with burstcount 4, rr_ptr=0 -> port 0 gets 4 consecutive beats with port 2 stalled; then port 2 gets 4 beats; rr_ptr=3 afterwards.
- Port 1 burst of 2 with out_wr_waitrequest pulsed high on the second beat -> grant stays on port 1 and no other port is granted until that beat is accepted.
- All 4 ports issue single-line writes continuously -> grants cycle 0,1,2,3,0; in_wr_writeresponsevalid bits follow the same order, each 1 cycle after its downstream response.
- Port 3 issues a fence (in_wr_request=1, burstcount=4) -> single beat forwarded with out_wr_request=1; state stays IDLE; response routed to bit 3.
- Issue 64 bursts with no responses -> 65th SOP stalled on all ports; the same-cycle response does not unblock it; the next cycle's SOP is accepted.
- Downstream response with FIFO empty -> no in_wr_writeresponsevalid; rsp_underflow_err=1 and held; reset mid-burst (beat 2 of 4) -> IDLE, error cleared, next SOP arbitrated from port 0.
